// File: rtl/matmul_stream_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// matmul_pkg
//   Shared types and helpers for the matrix-multiplier streaming controller.
//   - state_t    : controller state encoding (LOAD, EVAL, SEND)
//   - acc_width(): width of one result element of an N x N product of
//                  DW-bit unsigned operands; shared with the multiplier
//                  and the benches so all agree on AW.
// ---------------------------------------------------------------------------
package matmul_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        EVAL = 2'd1,
        SEND = 2'd2
    } state_t;

    // A dot product of N terms, each the product of two DW-bit values,
    // needs 2*DW bits per term plus clog2(N) bits of carry growth.
    function automatic int acc_width(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/matmul_stream_ctrl_if.sv
// ---------------------------------------------------------------------------
// matmul_stream_ctrl_if
//   Operand input stream and result output stream of matmul_stream_ctrl.
//
//   Handshake rule (both streams): a transfer happens on a rising clock
//   edge where valid && ready are both high. The producer holds data
//   (and last) stable and keeps valid high until that transfer; ready may
//   change freely and the consumer ignores data while valid is low.
//
//   Signals:
//     s_valid / s_ready / s_data  : operand elements, DW bits
//     m_valid / m_ready / m_data  : result elements, AW bits
//     m_last                      : marks the final result element
//   Modports:
//     master : system side (drives operands, consumes results)
//     slave  : controller side
// ---------------------------------------------------------------------------
interface matmul_stream_ctrl_if #(
    parameter int N  = 3,
    parameter int DW = 8
);
    import matmul_pkg::*;

    localparam int AW = acc_width(N, DW);

    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [AW-1:0] m_data;
    logic          m_last;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

endinterface

// File: rtl/matmul_stream_ctrl_serializer.sv
// ---------------------------------------------------------------------------
// mat_result_serializer
//   Captures the full N x N multiplier result on a one-cycle strobe and
//   plays it out row-major over a valid/ready stream.
//
//   Ports:
//     clk, rst  : clock, async active-high reset
//     capture   : strobe, high for the single cycle in which c_flat is
//                 stable; the result is registered on the closing edge
//     c_flat    : multiplier result, element (i,j) at [(i*N+j)*AW +: AW]
//     m_ready   : downstream ready
//     m_valid   : result element valid (registered)
//     m_data    : result element (registered)
//     m_last    : high with element N*N-1 (registered)
//     done      : combinational, high on the handshake of the last element
// ---------------------------------------------------------------------------
module mat_result_serializer
    import matmul_pkg::*;
#(
    parameter int N  = 3,
    parameter int AW = 18
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            capture,
    input  logic [N*N*AW-1:0] c_flat,
    input  logic            m_ready,
    output logic            m_valid,
    output logic [AW-1:0]   m_data,
    output logic            m_last,
    output logic            done
);

    localparam int NN = N * N;
    localparam int RW = $clog2(NN);

    logic [NN*AW-1:0] result;
    logic [RW-1:0]    r;

    assign done = m_valid && m_ready && m_last;

    // m_data is loaded one element ahead: on capture it takes element 0
    // straight from c_flat, on each handshake it takes element r+1 from
    // the captured copy, so it never changes while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result  <= '0;
            r       <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (capture) begin
            result  <= c_flat;
            r       <= '0;
            m_valid <= 1'b1;
            m_data  <= c_flat[AW-1:0];
            m_last  <= (NN == 1);
        end else if (m_valid && m_ready) begin
            if (m_last) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
                r       <= '0;
            end else begin
                r      <= r + RW'(1);
                m_data <= result[(int'(r) + 1) * AW +: AW];
                m_last <= ((int'(r) + 1) == (NN - 1));
            end
        end
    end

endmodule

// File: rtl/matmul_stream_ctrl.sv
// ---------------------------------------------------------------------------
// matmul_stream_ctrl
//   Streaming front/back end for an external combinational N x N matrix
//   multiplier. Collects 2*N*N operand elements (A row-major, then B
//   row-major) into registered A_flat/B_flat, waits one cycle for C_flat
//   to settle, captures it, and streams the N*N results out row-major.
//
//   Ports:
//     clk, rst : clock, async active-high reset
//     bus      : operand input stream and result output stream (slave)
//     A_flat   : operand A to multiplier, element (i,j) at [(i*N+j)*DW +: DW]
//     B_flat   : operand B to multiplier, same layout
//     C_flat   : multiplier result, element (i,j) at [(i*N+j)*AW +: AW]
//     busy     : high while evaluating or sending results
//     state    : current controller state, for observation
// ---------------------------------------------------------------------------
module matmul_stream_ctrl
    import matmul_pkg::*;
#(
    parameter  int N  = 3,
    parameter  int DW = 8,
    localparam int AW = acc_width(N, DW)
) (
    input  logic                clk,
    input  logic                rst,
    matmul_stream_ctrl_if.slave bus,
    output logic [N*N*DW-1:0]   A_flat,
    output logic [N*N*DW-1:0]   B_flat,
    input  logic [N*N*AW-1:0]   C_flat,
    output logic                busy,
    output state_t              state
);

    localparam int NN = N * N;
    localparam int KW = $clog2(2 * NN);

    logic [KW-1:0] k;
    logic          capture;
    logic          done;

    // s_ready is a register so it stays low through reset and rises on
    // the first edge after release; capture is high exactly during EVAL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LOAD;
            k           <= '0;
            bus.s_ready <= 1'b0;
            busy        <= 1'b0;
            capture     <= 1'b0;
            A_flat      <= '0;
            B_flat      <= '0;
        end else begin
            capture <= 1'b0;
            case (state)
                LOAD: begin
                    bus.s_ready <= 1'b1;
                    if (bus.s_valid && bus.s_ready) begin
                        if (int'(k) < NN) begin
                            A_flat[int'(k) * DW +: DW] <= bus.s_data;
                        end else begin
                            B_flat[(int'(k) - NN) * DW +: DW] <= bus.s_data;
                        end
                        if (int'(k) == 2 * NN - 1) begin
                            k           <= '0;
                            state       <= EVAL;
                            bus.s_ready <= 1'b0;
                            busy        <= 1'b1;
                            capture     <= 1'b1;
                        end else begin
                            k <= k + KW'(1);
                        end
                    end
                end
                EVAL: begin
                    state <= SEND;
                end
                SEND: begin
                    if (done) begin
                        state       <= LOAD;
                        bus.s_ready <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state       <= LOAD;
                    bus.s_ready <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    mat_result_serializer #(
        .N  (N),
        .AW (AW)
    ) u_serializer (
        .clk     (clk),
        .rst     (rst),
        .capture (capture),
        .c_flat  (C_flat),
        .m_ready (bus.m_ready),
        .m_valid (bus.m_valid),
        .m_data  (bus.m_data),
        .m_last  (bus.m_last),
        .done    (done)
    );

endmodule
